// File: rtl/ram_bist_ctrl.sv
// BIST sequencer for a dual-port RAM: writes complementary patterns through both
// ports, reads each back through the opposite port, and reports pass/fail.
module ram_bist_ctrl #(
  parameter int unsigned   AW      = 7,
  parameter int unsigned   DW      = 8,
  parameter logic [DW-1:0] PATTERN = 8'hAA
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [AW-1:0] err_addr,
  output logic [AW-1:0] a1,
  output logic [DW-1:0] d1,
  output logic          we1,
  output logic [AW-1:0] a2,
  output logic [DW-1:0] d2,
  output logic          we2,
  input  logic [DW-1:0] q1,
  input  logic [DW-1:0] q2
);

  localparam int unsigned KW = AW - 1;
  localparam logic [KW-1:0] KMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic          start_pend_q, start_pend_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic [DW-1:0] exp1_q, exp1_d, exp2_q, exp2_d;
  logic [AW-1:0] cadr1_q, cadr1_d, cadr2_q, cadr2_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [AW-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DW-1:0] d1_q, d1_d, d2_q, d2_d;
  logic          we1_q, we1_d, we2_q, we2_d;

  logic          mis1, mis2;
  logic [8:0]    err_sum;
  logic [DW-1:0] pat_q, pat_d;

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    k_d          = k_q;
    start_pend_d = start && (state_q == S_IDLE || state_q == S_DONE);
    pat_q        = p_q ? ~PATTERN : PATTERN;
    // Read-back expectations follow the RAM's one-cycle read latency
    cmp_vld_d    = (state_q == S_READ);
    exp1_d       = ~pat_q;
    exp2_d       = pat_q;
    cadr1_d      = a1_q;
    cadr2_d      = a2_q;

    mis1         = cmp_vld_q && (q1 != exp1_q);
    mis2         = cmp_vld_q && (q2 != exp2_q);
    err_sum      = {1'b0, err_count_q} + 9'(mis1) + 9'(mis2);
    err_count_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
    err_addr_d   = err_addr_q;
    if ((mis1 || mis2) && err_count_q == 8'd0) begin
      err_addr_d = mis1 ? cadr1_q : cadr2_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pend_q) begin
          state_d     = S_WRITE;
          p_d         = 1'b0;
          k_d         = '0;
          err_count_d = 8'd0;
          err_addr_d  = '0;
        end
      end
      S_WRITE: begin
        if (k_q == KMAX) begin
          state_d = S_READ;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_READ: begin
        if (k_q == KMAX) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (!p_q) begin
          state_d = S_WRITE;
          p_d     = 1'b1;
          k_d     = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q
    pat_d  = p_d ? ~PATTERN : PATTERN;
    busy_d = (state_d == S_WRITE || state_d == S_READ || state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_count_d == 8'd0);
    a1_d   = '0;
    a2_d   = '0;
    d1_d   = '0;
    d2_d   = '0;
    we1_d  = 1'b0;
    we2_d  = 1'b0;
    if (state_d == S_WRITE) begin
      we1_d = 1'b1;
      we2_d = 1'b1;
      a1_d  = {k_d, 1'b0};
      a2_d  = {k_d, 1'b1};
      d1_d  = pat_d;
      d2_d  = ~pat_d;
    end else if (state_d == S_READ) begin
      a1_d  = {k_d, 1'b1};
      a2_d  = {k_d, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      p_q          <= 1'b0;
      k_q          <= '0;
      start_pend_q <= 1'b0;
      cmp_vld_q    <= 1'b0;
      exp1_q       <= '0;
      exp2_q       <= '0;
      cadr1_q      <= '0;
      cadr2_q      <= '0;
      err_count_q  <= 8'd0;
      err_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      a1_q         <= '0;
      a2_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      we1_q        <= 1'b0;
      we2_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      k_q          <= k_d;
      start_pend_q <= start_pend_d;
      cmp_vld_q    <= cmp_vld_d;
      exp1_q       <= exp1_d;
      exp2_q       <= exp2_d;
      cadr1_q      <= cadr1_d;
      cadr2_q      <= cadr2_d;
      err_count_q  <= err_count_d;
      err_addr_q   <= err_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      a1_q         <= a1_d;
      a2_q         <= a2_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      we1_q        <= we1_d;
      we2_q        <= we2_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign a1        = a1_q;
  assign d1        = d1_q;
  assign we1       = we1_q;
  assign a2        = a2_q;
  assign d2        = d2_q;
  assign we2       = we2_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural dual-port RAM that can
// inject read faults.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass, we1, we2;
  logic [7:0] err_count, d1, d2, q1, q2;
  logic [6:0] err_addr, a1, a2;

  logic [7:0] mem [128];
  int         fault_mode;
  int         checks = 0;
  int         failures = 0;

  // Values captured on the first cycle after a start is acted on
  logic [6:0] f_a1, f_a2;
  logic [7:0] f_d1, f_d2, f_err;
  logic       f_we1, f_we2, f_done;
  int         lat, bcnt;

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .err_addr(err_addr),
    .a1(a1), .d1(d1), .we1(we1), .a2(a2), .d2(d2), .we2(we2),
    .q1(q1), .q2(q2)
  );

  function automatic logic [7:0] rd(input logic [6:0] a, input logic [7:0] v);
    case (fault_mode)
      1: return (a == 7'h05) ? (v | 8'h01) : v;
      2: return (a == 7'h10 || a == 7'h11) ? (v ^ 8'h01) : v;
      3: return 8'h00;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (we1) mem[a1] <= d1;
    if (we2) mem[a2] <= d2;
    q1 <= rd(a1, mem[a1]);
    q2 <= rd(a2, mem[a2]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then run until done with a bounded edge count.
  task automatic run(input bit mid_start);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        f_a1 = a1; f_a2 = a2; f_d1 = d1; f_d2 = d2;
        f_we1 = we1; f_we2 = we2; f_done = done; f_err = err_count;
      end
      if (mid_start && n == 100) start = 1'b1;
      if (mid_start && n == 101) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 32'(lat), 32'd259);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fault_mode = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we1", 32'(we1), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Abort mid-WRITE with an async reset
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("midw_we1", 32'(we1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we1", 32'(we1), 32'd0);
    chk("abort_we2", 32'(we2), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_we1", 32'(we1 | we2), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Clean run
    run(1'b0);
    chk("clean_a1", 32'(f_a1), 32'h00);
    chk("clean_d1", 32'(f_d1), 32'hAA);
    chk("clean_a2", 32'(f_a2), 32'h01);
    chk("clean_d2", 32'(f_d2), 32'h55);
    chk("clean_we", 32'({f_we1, f_we2}), 32'h3);
    chk("clean_lat", 32'(lat), 32'd259);
    chk("clean_busy_cycles", 32'(bcnt), 32'd258);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_err", 32'(err_count), 32'd0);
    chk("clean_eaddr", 32'(err_addr), 32'd0);
    chk("clean_idle_out", 32'({we1, we2, a1, a2, d1, d2}), 32'd0);

    // Stuck-at-1 bit 0 at address 5: only the ~AA -> AA pass fails
    fault_mode = 1;
    run(1'b0);
    chk("stuck_lat", 32'(lat), 32'd259);
    chk("stuck_err", 32'(err_count), 32'd1);
    chk("stuck_eaddr", 32'(err_addr), 32'h05);
    chk("stuck_pass", 32'(pass), 32'd0);

    // Both ports fail in the same cycle in both passes
    fault_mode = 2;
    run(1'b0);
    chk("dual_err", 32'(err_count), 32'd4);
    chk("dual_eaddr", 32'(err_addr), 32'h11);
    chk("dual_pass", 32'(pass), 32'd0);

    // Every compare fails: counter saturates
    fault_mode = 3;
    run(1'b0);
    chk("sat_err", 32'(err_count), 32'd255);
    chk("sat_eaddr", 32'(err_addr), 32'h01);
    chk("sat_pass", 32'(pass), 32'd0);

    // Restart from DONE clears results; start during READ is ignored
    fault_mode = 0;
    run(1'b1);
    chk("rst_done_drop", 32'(f_done), 32'd0);
    chk("rst_err_clear", 32'(f_err), 32'd0);
    chk("rst_lat", 32'(lat), 32'd259);
    chk("rst_busy_cycles", 32'(bcnt), 32'd258);
    chk("rst_pass", 32'(pass), 32'd1);
    chk("rst_err", 32'(err_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("done_held", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
